// File: rtl/oscillator_sequencer.sv
// rtl/oscillator_sequencer.sv - step-table sequencer driving oscillator divisor/duty/waveform
// Steps are held for a programmed number of consumed samples; the next entry is always prefetched.
module oscillator_sequencer #(
    parameter int STEPS     = 16,
    parameter int DUR_WIDTH = 16,
    localparam int AW       = $clog2(STEPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_cfg_we,
    input  logic [AW-1:0]        i_cfg_addr,
    input  logic [31:0]          i_cfg_divisor,
    input  logic [7:0]           i_cfg_duty,
    input  logic                 i_cfg_waveform,
    input  logic [DUR_WIDTH-1:0] i_cfg_duration,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_loop,
    input  logic [AW-1:0]        i_last_step,
    input  logic                 i_sample_tick,
    output logic [31:0]          o_divisor,
    output logic [7:0]           o_duty,
    output logic                 o_waveform,
    output logic                 o_mute,
    output logic                 o_busy,
    output logic [AW-1:0]        o_step,
    output logic                 o_done
);

    localparam int EW = 41 + DUR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [EW-1:0]        r_mem [STEPS];
    logic [EW-1:0]        r_rd_data;
    logic [31:0]          r_divisor;
    logic [7:0]           r_duty;
    logic                 r_waveform;
    logic                 r_mute;
    logic [AW-1:0]        r_step;
    logic [DUR_WIDTH-1:0] r_remain;
    logic                 r_done;

    logic                 w_load;
    logic                 w_finish;
    logic                 w_abort;
    logic                 w_step_end;
    logic                 w_continue;
    logic [AW-1:0]        w_nxt;
    logic [AW-1:0]        w_step_next;
    logic [AW-1:0]        w_rd_addr;
    logic [31:0]          w_rd_divisor;
    logic [7:0]           w_rd_duty;
    logic                 w_rd_waveform;
    logic [DUR_WIDTH-1:0] w_rd_duration;

    function automatic logic [AW-1:0] f_nxt(input logic [AW-1:0] s, input logic [AW-1:0] last);
        return (s == last) ? '0 : s + AW'(1);
    endfunction

    assign w_rd_divisor  = r_rd_data[EW-1 -: 32];
    assign w_rd_duty     = r_rd_data[DUR_WIDTH+8 -: 8];
    assign w_rd_waveform = r_rd_data[DUR_WIDTH];
    assign w_rd_duration = r_rd_data[DUR_WIDTH-1:0];

    assign w_nxt      = f_nxt(r_step, i_last_step);
    assign w_step_end = (r_state == S_PLAY) && i_sample_tick && (r_remain == DUR_WIDTH'(1));
    assign w_continue = (r_step != i_last_step) || i_loop;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_PRIME;
            S_PRIME: begin
                w_state_next = S_PLAY;
                w_load       = 1'b1;
            end
            S_PLAY: begin
                if (w_step_end) begin
                    if (w_continue) begin
                        w_load = 1'b1;
                    end else begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (i_stop) begin
            w_state_next = S_IDLE;
            w_load       = 1'b0;
            w_finish     = 1'b0;
            w_abort      = 1'b1;
        end
    end

    // Address the entry after the step that will be current next cycle, so back-to-back
    // single-sample steps still find the right entry already read.
    always_comb begin
        w_step_next = r_step;
        if (r_state == S_PRIME) w_step_next = '0;
        else if (w_load)        w_step_next = w_nxt;
        w_rd_addr = (r_state == S_IDLE) ? '0 : f_nxt(w_step_next, i_last_step);
    end

    // Read-before-write: a same-cycle write is not seen by this read.
    always_ff @(posedge clk) begin
        if (i_cfg_we) r_mem[i_cfg_addr] <= {i_cfg_divisor, i_cfg_duty, i_cfg_waveform, i_cfg_duration};
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_divisor  <= '0;
            r_duty     <= '0;
            r_waveform <= 1'b0;
            r_mute     <= 1'b1;
            r_step     <= '0;
            r_remain   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_abort || w_finish) begin
                r_divisor <= '0;
                r_mute    <= 1'b1;
            end else if (w_load) begin
                r_divisor  <= w_rd_divisor;
                r_duty     <= w_rd_duty;
                r_waveform <= w_rd_waveform;
                r_mute     <= 1'b0;
                r_step     <= w_step_next;
                r_remain   <= (w_rd_duration == '0) ? DUR_WIDTH'(1) : w_rd_duration;
            end else if (r_state == S_PLAY && i_sample_tick) begin
                r_remain <= r_remain - DUR_WIDTH'(1);
            end
        end
    end

    assign o_divisor  = r_divisor;
    assign o_duty     = r_duty;
    assign o_waveform = r_waveform;
    assign o_mute     = r_mute;
    assign o_busy     = (r_state != S_IDLE);
    assign o_step     = r_step;
    assign o_done     = r_done;

endmodule

// File: tb/tb_oscillator_sequencer.sv
// tb/tb_oscillator_sequencer.sv - self-checking bench for oscillator_sequencer
// Expected outputs come from a per-sample expansion of the step table.
module tb_oscillator_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_cfg_we;
    logic [3:0]  i_cfg_addr;
    logic [31:0] i_cfg_divisor;
    logic [7:0]  i_cfg_duty;
    logic        i_cfg_waveform;
    logic [15:0] i_cfg_duration;
    logic        i_start, i_stop, i_loop;
    logic [3:0]  i_last_step;
    logic        i_sample_tick;
    logic [31:0] o_divisor;
    logic [7:0]  o_duty;
    logic        o_waveform, o_mute, o_busy, o_done;
    logic [3:0]  o_step;

    logic [31:0] m_div  [16];
    logic [7:0]  m_duty [16];
    logic        m_wav  [16];
    logic [15:0] m_dur  [16];

    int nerr = 0;
    int nchk = 0;

    oscillator_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_divisor(i_cfg_divisor),
        .i_cfg_duty(i_cfg_duty), .i_cfg_waveform(i_cfg_waveform), .i_cfg_duration(i_cfg_duration),
        .i_start(i_start), .i_stop(i_stop), .i_loop(i_loop), .i_last_step(i_last_step),
        .i_sample_tick(i_sample_tick),
        .o_divisor(o_divisor), .o_duty(o_duty), .o_waveform(o_waveform), .o_mute(o_mute),
        .o_busy(o_busy), .o_step(o_step), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_cycle(input logic tk);
        i_sample_tick = tk;
        @(posedge clk); #1;
        i_sample_tick = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] dv, input logic [7:0] dt, input logic wv,
                      input logic [15:0] du);
        i_cfg_we = 1'b1; i_cfg_addr = 4'(a); i_cfg_divisor = dv;
        i_cfg_duty = dt; i_cfg_waveform = wv; i_cfg_duration = du;
        @(posedge clk); #1;
        i_cfg_we = 1'b0;
        m_div[a] = dv; m_duty[a] = dt; m_wav[a] = wv; m_dur[a] = du;
    endtask

    task automatic expect_step(input int s);
        chk("divisor", o_divisor, m_div[s]);
        chk("duty", 32'(o_duty), 32'(m_duty[s]));
        chk("waveform", 32'(o_waveform), 32'(m_wav[s]));
        chk("step", 32'(o_step), 32'(s));
        chk("mute_play", 32'(o_mute), 32'd0);
        chk("busy_play", 32'(o_busy), 32'd1);
        chk("done_play", 32'(o_done), 32'd0);
    endtask

    task automatic expect_idle(input int s, input logic d);
        chk("idle_divisor", o_divisor, 32'd0);
        chk("idle_mute", 32'(o_mute), 32'd1);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_step", 32'(o_step), 32'(s));
        chk("idle_done", 32'(o_done), 32'(d));
    endtask

    task automatic begin_play(input logic lp);
        i_loop = lp; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("prime_busy", 32'(o_busy), 32'd1);
        chk("prime_mute", 32'(o_mute), 32'd1);
        // A tick in the prime cycle must not be counted.
        tick_cycle(1'($urandom_range(0, 1)));
    endtask

    // period 0 = random ticks; otherwise a tick on every period-th cycle.
    task automatic play(input logic lp, input int period, input logic poke_start);
        int q[$];
        int cyc;
        logic tk;
        for (int r = 0; r < (lp ? 2 : 1); r++)
            for (int s = 0; s <= int'(i_last_step); s++)
                for (int d = 0; d < ((m_dur[s] == 16'd0) ? 1 : int'(m_dur[s])); d++)
                    q.push_back(s);
        begin_play(lp);
        expect_step(q[0]);
        cyc = 0;
        while (q.size() > (lp ? 1 : 0) && cyc < 3000) begin
            tk = (period == 0) ? 1'($urandom_range(0, 1)) : 1'((cyc % period) == period - 1);
            i_sample_tick = tk;
            i_start = poke_start & ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            cyc++;
            if (tk) void'(q.pop_front());
            if (q.size() > 0) expect_step(q[0]);
        end
        i_sample_tick = 1'b0; i_start = 1'b0;
        chk("play_timeout", 32'(cyc < 3000), 32'd1);
        if (lp) begin
            i_stop = 1'b1;
            @(posedge clk); #1;
            i_stop = 1'b0;
            expect_idle(q[0], 1'b0);
        end else begin
            expect_idle(int'(i_last_step), 1'b1);
            @(posedge clk); #1;
            chk("done_fall", 32'(o_done), 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_divisor = '0; i_cfg_duty = '0;
        i_cfg_waveform = 1'b0; i_cfg_duration = '0; i_start = 1'b0; i_stop = 1'b0;
        i_loop = 1'b0; i_last_step = '0; i_sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_duty", 32'(o_duty), 32'd0);
        chk("rst_wave", 32'(o_waveform), 32'd0);
        expect_idle(0, 1'b0);

        // Basic three-step sequence, tick every cycle.
        wr(0, 32'h100, 8'h10, 1'b0, 16'd3);
        wr(1, 32'h200, 8'h20, 1'b1, 16'd1);
        wr(2, 32'h300, 8'h30, 1'b0, 16'd2);
        i_last_step = 4'd2;
        play(1'b0, 1, 1'b0);

        // Looping, tick every 4th cycle, with start pokes ignored.
        play(1'b1, 4, 1'b1);

        // Stop on the boundary tick of step 0.
        begin_play(1'b0);
        tick_cycle(1'b1);
        tick_cycle(1'b1);
        i_stop = 1'b1;
        tick_cycle(1'b1);
        i_stop = 1'b0;
        expect_idle(0, 1'b0);
        @(posedge clk); #1;
        chk("stop_no_done", 32'(o_done), 32'd0);

        // Duration 0 behaves as 1; start during play ignored.
        wr(1, 32'h200, 8'h20, 1'b1, 16'd0);
        play(1'b0, 1, 1'b1);

        // Table write timing against the step boundary.
        wr(0, 32'h111, 8'h01, 1'b0, 16'd10);
        wr(1, 32'h222, 8'h02, 1'b1, 16'd2);
        i_last_step = 4'd1;
        for (int pass = 0; pass < 2; pass++) begin
            begin_play(1'b0);
            for (int k = 1; k <= 10; k++) begin
                i_cfg_we = (k == 3) || (k == (pass == 0 ? 5 : 10));
                i_cfg_addr = (k == 3) ? 4'd0 : 4'd1;
                i_cfg_divisor = (k == 3) ? 32'h999 : (pass == 0 ? 32'hABC : 32'hDEF);
                i_cfg_duty = (k == 3) ? 8'h01 : 8'h02;
                i_cfg_waveform = (k != 3);
                i_cfg_duration = (k == 3) ? 16'd10 : 16'd2;
                tick_cycle(1'b1);
                i_cfg_we = 1'b0;
                if (k == 4) chk("live_write_held", o_divisor, 32'h111);
            end
            chk("nxt_write", o_divisor, pass == 0 ? 32'hABC : 32'h222);
            tick_cycle(1'b1);
            tick_cycle(1'b1);
            expect_idle(1, 1'b1);
            wr(0, 32'h111, 8'h01, 1'b0, 16'd10);
            wr(1, 32'h222, 8'h02, 1'b1, 16'd2);
        end

        // Randomized tables, lengths, loop mode and tick patterns.
        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < 4; s++)
                wr(s, $urandom, 8'($urandom), 1'($urandom), 16'($urandom_range(0, 4)));
            i_last_step = 4'($urandom_range(0, 3));
            play(1'($urandom_range(0, 1)), 0, 1'b1);
        end

        // Reset mid-play, then replay the preserved table.
        wr(0, 32'h100, 8'h10, 1'b0, 16'd3);
        wr(1, 32'h200, 8'h20, 1'b1, 16'd1);
        wr(2, 32'h300, 8'h30, 1'b0, 16'd2);
        i_last_step = 4'd2;
        begin_play(1'b0);
        tick_cycle(1'b1);
        tick_cycle(1'b1);
        tick_cycle(1'b1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("mid_rst_duty", 32'(o_duty), 32'd0);
        chk("mid_rst_wave", 32'(o_waveform), 32'd0);
        expect_idle(0, 1'b0);
        play(1'b0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/oscillator_sequencer.md
# oscillator_sequencer

Sequencer that drives the control inputs (`divisor`, `duty`, `waveform`) of the audio oscillator from a small programmable step table, holding each step for a programmed number of consumed samples. It sits between the configuration bus and the oscillator. It counts oscillator stream transactions so that step boundaries are sample-accurate. It also provides a mute gate for the downstream sample path.

## Interface
- `STEPS`, 16, table depth; must be a power of two, ≥2; `AW = $clog2(STEPS)`
- `DUR_WIDTH`, 16, width of per-step duration in samples

- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `cfg_we`  in  1  table write strobe
- `cfg_addr`  in  AW  table entry index
- `cfg_divisor`  in  32  step phase increment
- `cfg_duty`  in  8  step duty value
- `cfg_waveform`  in  1  step waveform select
- `cfg_duration`  in  DUR_WIDTH  step length in samples; 0 treated as 1
- `start`  in  1  begin playback at step 0 (level-sampled)
- `stop`  in  1  abort playback
- `loop`  in  1  at end of sequence: restart at step 0 instead of finishing
- `last_step`  in  AW  index of final step
- `sample_tick`  in  1  one pulse per consumed oscillator sample (`tvalid & tready`)
- `divisor`  out  32  to oscillator
- `duty`  out  8  to oscillator
- `waveform`  out  1  to oscillator
- `mute`  out  1  1 = downstream gate forces samples to zero
- `busy`  out  1  1 in PRIME or PLAY
- `step`  out  AW  index of step currently on outputs
- `done`  out  1  one-cycle pulse when a non-looping sequence completes

## Operation
- Table: STEPS × (32+8+1+DUR_WIDTH) bits, synchronous write and read, read-before-write on a same-address collision. Contents are not reset.
- States: IDLE, PRIME, PLAY.
- IDLE:
  - `divisor=0` freezes the oscillator. `mute=1`. `busy=0`.
  - Read address is 0.
  - `start=1` → PRIME.
- PRIME (one cycle):
  - Read data holds entry 0.
  - At the edge: load the outputs from the entry, `step<=0`, `remain<=max(duration,1)`, `mute<=0`.
  - → PLAY.
- PLAY:
  - Read address is `nxt`, defined as `step==last_step ? 0 : step+1`. The read data is therefore always the prefetched next entry.
  - On `sample_tick` with `remain>1`: `remain<=remain-1`.
  - On `sample_tick` with `remain==1`, the step ends:
    - If `step!=last_step`, or `loop=1`: load the outputs and `remain` from the prefetched entry, `step<=nxt`, stay in PLAY. There is zero gap between steps.
    - Otherwise: → IDLE, `divisor<=0`, `mute<=1`, `done<=1` for one cycle.
- `stop=1` in any state: → IDLE at the next edge with IDLE output values. No `done`. `stop` has priority over `start` and `sample_tick`.
- `start` while `busy`: ignored.
- `last_step` and `loop` are sampled at each step end, so changing them mid-sequence takes effect at the next boundary.
- `cfg` writes are allowed in any state:
  - A write to the currently playing entry does not alter the outputs.
  - A write to entry `nxt` is used only if it lands ≥2 cycles before the boundary edge. Otherwise the old value is used.
- `last_step=0` with `loop=1`: step 0 repeats indefinitely, reloading its table values at each boundary.
- `remain` is DUR_WIDTH bits. `duration=2^DUR_WIDTH-1` gives the maximum hold length.

## Timing
- Reset values: `divisor=0`, `duty=0`, `waveform=0`, `mute=1`, `busy=0`, `step=0`, `done=0`, state IDLE.
- `start` sampled at edge N:
  - `busy=1` after N.
  - Step 0 values appear on the outputs after edge N+1.
- A step of duration D occupies exactly D `sample_tick`s. The outputs switch on the same edge that registers the D-th tick.
- A tick arriving in the PRIME cycle is not counted.
- `done` rises on the edge after the final tick and falls on the next edge.
- Reset mid-PLAY: all outputs return to reset values at that edge. The table is preserved.

## Test plan
- Load steps 0..2 = (divisor 0x100/dur 3, 0x200/dur 1, 0x300/dur 2), `last_step=2`, `loop=0`, `start`, tick every cycle:
  - `divisor` sequence is 0x100×3, 0x200×1, 0x300×2, then 0.
  - `mute` is 1 afterwards.
  - `done` pulses once.
- Same table with `loop=1`, ticks every 4th cycle: `step` cycles 0,1,2,0,1; `done` never asserts.
- Assert `stop` in the same cycle as a boundary tick: next state is IDLE, `divisor=0`, no `done`, no step advance.
- Duration 0 on step 1 behaves identically to duration 1. Assert `start` during PLAY: no restart.
- While step 0 plays (dur 10): write step 1 with divisor 0xABC 5 cycles before the boundary and observe 0xABC; repeat with the write at the boundary cycle and observe the old value.
- Assert `reset_n=0` mid-PLAY: outputs reach reset values next cycle. A subsequent `start` replays the unchanged table.
